// File: rtl/seq_alu.sv
// Multi-cycle accumulator ALU: single-cycle logic/arith ops, iterative shift-add MUL and restoring DIV.
// Optional status flags (flag_z/flag_n/flag_c) are built only when SEQ_ALU_FLAGS_EN is defined.
module seq_alu #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             div_zero
`ifdef SEQ_ALU_FLAGS_EN
    ,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c
`endif
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_MUL  = 4'h2;
    localparam logic [3:0] OP_DIV  = 4'h3;
    localparam logic [3:0] OP_SHL  = 4'h4;
    localparam logic [3:0] OP_SHR  = 4'h5;
    localparam logic [3:0] OP_ROL  = 4'h6;
    localparam logic [3:0] OP_ROR  = 4'h7;
    localparam logic [3:0] OP_AND  = 4'h8;
    localparam logic [3:0] OP_OR   = 4'h9;
    localparam logic [3:0] OP_XOR  = 4'hA;
    localparam logic [3:0] OP_NOR  = 4'hB;
    localparam logic [3:0] OP_NAND = 4'hC;
    localparam logic [3:0] OP_XNOR = 4'hD;
    localparam logic [3:0] OP_GT   = 4'hE;
    localparam logic [3:0] OP_EQ   = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [WIDTH-1:0] alu_single(input logic [3:0] op,
                                                    input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        r = '0;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_SHL:  r = {a[WIDTH-2:0], 1'b0};
            OP_SHR:  r = {1'b0, a[WIDTH-1:1]};
            OP_ROL:  r = {a[WIDTH-2:0], a[WIDTH-1]};
            OP_ROR:  r = {a[0], a[WIDTH-1:1]};
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NOR:  r = ~(a | b);
            OP_NAND: r = ~(a & b);
            OP_XNOR: r = ~(a ^ b);
            OP_GT:   r = {{(WIDTH-1){1'b0}}, (a > b)};
            OP_EQ:   r = {{(WIDTH-1){1'b0}}, (a == b)};
            default: r = '0;
        endcase
        return r;
    endfunction

    state_t           state_r, state_next_s;
    logic [CNT_W-1:0] counter_r;
    logic [WIDTH-1:0] acc_r, work_r, opd_r;
    logic             is_div_r;
    logic             busy_r, done_r, div_zero_r;
    logic [WIDTH-1:0] result_r, result_hi_r;

    logic             accept_s, iter_op_s, last_step_s;
    logic [WIDTH:0]   mul_sum_s, div_sh_s;
    logic             div_ge_s;
    logic [WIDTH-1:0] div_diff_s, step_acc_s, step_work_s;
    logic             fin_en_s, fin_dz_s;
    logic [WIDTH-1:0] fin_result_s, fin_hi_s;

    assign accept_s    = start && (state_r != ITER);
    assign iter_op_s   = (opcode == OP_MUL) || ((opcode == OP_DIV) && (operand2 != '0));
    assign last_step_s = (state_r == ITER) && (counter_r == '0);

    // Next-state decode for the IDLE/ITER/DONE controller
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    state_next_s = iter_op_s ? ITER : DONE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ITER: begin
                if (counter_r == '0) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = ITER;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // One iteration: MUL shifts {acc,work} right after a conditional add; DIV shifts left and trial-subtracts
    always_comb begin
        mul_sum_s  = {1'b0, acc_r} + (work_r[0] ? {1'b0, opd_r} : {(WIDTH+1){1'b0}});
        div_sh_s   = {acc_r, work_r[WIDTH-1]};
        div_ge_s   = (div_sh_s >= {1'b0, opd_r});
        div_diff_s = div_sh_s[WIDTH-1:0] - opd_r;
        if (is_div_r) begin
            step_acc_s  = div_ge_s ? div_diff_s : div_sh_s[WIDTH-1:0];
            step_work_s = {work_r[WIDTH-2:0], div_ge_s};
        end else begin
            step_acc_s  = mul_sum_s[WIDTH:1];
            step_work_s = {mul_sum_s[0], work_r[WIDTH-1:1]};
        end
    end

    // Values loaded into the visible result registers on the edge that enters DONE
    always_comb begin
        fin_en_s     = 1'b0;
        fin_result_s = '0;
        fin_hi_s     = '0;
        fin_dz_s     = 1'b0;
        if (accept_s && !iter_op_s) begin
            fin_en_s = 1'b1;
            if (opcode == OP_DIV) begin
                fin_result_s = '1;
                fin_hi_s     = operand1;
                fin_dz_s     = 1'b1;
            end else begin
                fin_result_s = alu_single(opcode, operand1, operand2);
            end
        end else if (last_step_s) begin
            fin_en_s     = 1'b1;
            fin_result_s = step_work_s;
            fin_hi_s     = step_acc_s;
        end else begin
            fin_en_s = 1'b0;
        end
    end

    // State, handshake outputs, working registers and results
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            counter_r   <= '0;
            acc_r       <= '0;
            work_r      <= '0;
            opd_r       <= '0;
            is_div_r    <= 1'b0;
            result_r    <= '0;
            result_hi_r <= '0;
            div_zero_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s == ITER);
            done_r  <= (state_next_s == DONE);
            if (accept_s && iter_op_s) begin
                counter_r <= CNT_W'(WIDTH-1);
                acc_r     <= '0;
                work_r    <= operand1;
                opd_r     <= operand2;
                is_div_r  <= (opcode == OP_DIV);
            end else if (state_r == ITER) begin
                counter_r <= counter_r - CNT_W'(1);
                acc_r     <= step_acc_s;
                work_r    <= step_work_s;
            end
            if (fin_en_s) begin
                result_r    <= fin_result_s;
                result_hi_r <= fin_hi_s;
                div_zero_r  <= fin_dz_s;
            end
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign result    = result_r;
    assign result_hi = result_hi_r;
    assign div_zero  = div_zero_r;

`ifdef SEQ_ALU_FLAGS_EN
    function automatic logic carry_of(input logic [3:0] op,
                                      input logic [WIDTH-1:0] a,
                                      input logic [WIDTH-1:0] b);
        logic [WIDTH:0] sum;
        logic           c;
        sum = {1'b0, a} + {1'b0, b};
        case (op)
            OP_ADD:         c = sum[WIDTH];
            OP_SUB:         c = (a < b);
            OP_SHL, OP_ROL: c = a[WIDTH-1];
            OP_SHR, OP_ROR: c = a[0];
            default:        c = 1'b0;
        endcase
        return c;
    endfunction

    logic fin_c_s;
    logic flag_z_r, flag_n_r, flag_c_r;

    // Carry/borrow/overflow source for the op that is finishing
    always_comb begin
        fin_c_s = 1'b0;
        if (accept_s && !iter_op_s) begin
            fin_c_s = (opcode == OP_DIV) ? 1'b1 : carry_of(opcode, operand1, operand2);
        end else if (last_step_s) begin
            fin_c_s = !is_div_r && (step_acc_s != '0);
        end else begin
            fin_c_s = 1'b0;
        end
    end

    // Flags track the result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            flag_z_r <= 1'b0;
            flag_n_r <= 1'b0;
            flag_c_r <= 1'b0;
        end else if (fin_en_s) begin
            flag_z_r <= (fin_result_s == '0);
            flag_n_r <= fin_result_s[WIDTH-1];
            flag_c_r <= fin_c_s;
        end
    end

    assign flag_z = flag_z_r;
    assign flag_n = flag_n_r;
    assign flag_c = flag_c_r;
`endif

endmodule
